dpath_seq: RTL and testbench

- Program sequencer that drives the command side of `dpath`: it supplies `com` and `datain` to the datapath and reads back `accum`.
- Holds a small loadable program memory and executes it on `start`.
- Each ISSUE instruction becomes exactly one non-NOP command cycle to `dpath`; the jump and halt instructions are handled locally.
- Sits between the top-level controller/bench and `dpath`, replacing hand-driven command sequences.

---
 rtl/dpath_seq_if.sv | 28 ++
 rtl/dpath_seq.sv | 111 +++++++++++
 tb/tb_dpath_seq.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpath_seq_if.sv
// Sequencer bus: program load, run control/status and the command link to dpath.
interface dpath_seq_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3,
  parameter int ADDR_W = 4
);
  logic                      start;
  logic                      prog_we;
  logic [ADDR_W-1:0]         prog_addr;
  logic [2+SEL_W+DATA_W-1:0] prog_wdata;
  logic [DATA_W-1:0]         accum;
  logic [SEL_W-1:0]          com;
  logic [DATA_W-1:0]         datain;
  logic                      busy;
  logic                      done;
  logic                      abort;
  logic [ADDR_W-1:0]         pc;

  modport master (
    output start, prog_we, prog_addr, prog_wdata, accum,
    input  com, datain, busy, done, abort, pc
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_wdata, accum,
    output com, datain, busy, done, abort, pc
  );
endinterface

// File: rtl/dpath_seq.sv
// Program sequencer for dpath: runs a loaded instruction list and turns each
// ISSUE into one registered command cycle; jumps and halt resolve locally.
module dpath_seq #(
  parameter int               DATA_W    = 16,
  parameter int               SEL_W     = 3,
  parameter int               ADDR_W    = 4,
  parameter logic [SEL_W-1:0] NOP_COM   = '0,
  parameter int               MAX_STEPS = 255
) (
  input  logic        clk,
  input  logic        rst,
  dpath_seq_if.slave  bus
);
  localparam int          IW       = 2 + SEL_W + DATA_W;
  localparam int          NWORDS   = 2 ** ADDR_W;
  localparam logic [7:0]  STEP_LIM = 8'(MAX_STEPS);
  localparam logic [1:0]  OP_ISSUE = 2'b00;
  localparam logic [1:0]  OP_JZ    = 2'b01;
  localparam logic [1:0]  OP_JMP   = 2'b10;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FIN} state_t;

  state_t              state, state_n;
  logic [IW-1:0]       mem [NWORDS];
  logic [IW-1:0]       ir;
  logic [ADDR_W-1:0]   pc_q, pc_n;
  logic [7:0]          step_q, step_n;
  logic                abort_q, abort_n;
  logic [SEL_W-1:0]    com_q, com_n;
  logic [DATA_W-1:0]   datain_q, datain_n;

  logic [1:0]          op;
  logic [SEL_W-1:0]    sel;
  logic [DATA_W-1:0]   data;

  assign op   = ir[IW-1 -: 2];
  assign sel  = ir[DATA_W +: SEL_W];
  assign data = ir[DATA_W-1:0];

  // Memory is not reset; loads are only accepted while idle so a running
  // program can never be modified underneath itself.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state == IDLE) mem[bus.prog_addr] <= bus.prog_wdata;
    if (state == FETCH) ir <= mem[pc_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc_q     <= '0;
      step_q   <= '0;
      abort_q  <= 1'b0;
      com_q    <= NOP_COM;
      datain_q <= '0;
    end else begin
      state    <= state_n;
      pc_q     <= pc_n;
      step_q   <= step_n;
      abort_q  <= abort_n;
      com_q    <= com_n;
      datain_q <= datain_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc_q;
    step_n   = step_q;
    abort_n  = abort_q;
    com_n    = NOP_COM;
    datain_n = datain_q;
    case (state)
      IDLE: if (bus.start) begin
        pc_n    = '0;
        step_n  = '0;
        abort_n = 1'b0;
        state_n = FETCH;
      end
      FETCH: state_n = EXEC;
      EXEC: begin
        if (step_q == STEP_LIM) begin
          abort_n = 1'b1;
          state_n = FIN;
        end else begin
          step_n  = step_q + 8'd1;
          state_n = FETCH;
          case (op)
            OP_ISSUE: begin
              com_n    = sel;
              datain_n = data;
              pc_n     = pc_q + 1'b1;
            end
            // accum already reflects an ISSUE executed just before this one
            OP_JZ:  pc_n = (bus.accum == '0) ? data[ADDR_W-1:0] : pc_q + 1'b1;
            OP_JMP: pc_n = data[ADDR_W-1:0];
            default: state_n = FIN;
          endcase
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.com    = com_q;
  assign bus.datain = datain_q;
  assign bus.busy   = (state == FETCH) || (state == EXEC);
  assign bus.done   = (state == FIN);
  assign bus.abort  = abort_q;
  assign bus.pc     = pc_q;
endmodule

// File: tb/tb_dpath_seq.sv
// Bench for dpath_seq: a load-on-command accumulator stands in for dpath and a
// program interpreter predicts the issued command stream and final status.
module tb_dpath_seq;
  localparam int DW = 16, SW = 3, AW = 4, IW = 2 + SW + DW, NWORDS = 16, MAXS = 255;
  localparam logic [SW-1:0] NOP = '0;

  typedef struct packed {logic [SW-1:0] sel; logic [DW-1:0] data;} cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dpath_seq_if #(.DATA_W(DW), .SEL_W(SW), .ADDR_W(AW)) bus();
  dpath_seq #(.DATA_W(DW), .SEL_W(SW), .ADDR_W(AW), .NOP_COM(NOP), .MAX_STEPS(MAXS))
    dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // dpath stand-in: accum loads datain on every non-NOP command
  logic [DW-1:0] acc;
  logic          acc_set = 1'b0;
  logic [DW-1:0] acc_val = '0;
  always @(posedge clk) begin
    if (acc_set) acc <= acc_val;
    else if (bus.com !== NOP) acc <= bus.datain;
  end
  assign bus.accum = acc;

  logic [IW-1:0] prog [NWORDS];
  int n_checks = 0, n_fail = 0;
  cmd_t got_q[$], exp_q[$];
  int busy_cyc, both_hi, exp_steps;
  bit timed_out, exp_abort;
  logic got_abort, abort_first;
  logic [AW-1:0] got_pc, exp_pc;

  function automatic logic [IW-1:0] mk(input logic [1:0] op, input logic [SW-1:0] sel,
                                       input logic [DW-1:0] d);
    return {op, sel, d};
  endfunction

  function automatic bit q_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic write_word(input int a, input logic [IW-1:0] w);
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = AW'(a); bus.prog_wdata = w; prog[a] = w;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic preset_acc(input logic [DW-1:0] v);
    @(negedge clk); acc_set = 1'b1; acc_val = v;
    @(negedge clk); acc_set = 1'b0;
  endtask

  // Interpreter over the bench's own copy of the program.
  task automatic model(input logic [DW-1:0] acc0);
    logic [DW-1:0] a;
    logic [IW-1:0] w;
    int p, steps;
    a = acc0; p = 0; steps = 0; exp_abort = 1'b0;
    exp_q.delete();
    while (1) begin
      w = prog[p];
      if (steps == MAXS) begin exp_abort = 1'b1; break; end
      steps++;
      if (w[IW-1 -: 2] == 2'd0) begin
        if (w[DW +: SW] != NOP) begin exp_q.push_back({w[DW +: SW], w[DW-1:0]}); a = w[DW-1:0]; end
        p = (p + 1) % NWORDS;
      end else if (w[IW-1 -: 2] == 2'd1) p = (a == '0) ? int'(w[AW-1:0]) : (p + 1) % NWORDS;
      else if (w[IW-1 -: 2] == 2'd2) p = int'(w[AW-1:0]);
      else break;
    end
    exp_steps = steps; exp_pc = AW'(p);
  endtask

  // Pulse start, optionally writing word 0 in the same cycle, optionally
  // hammering start/prog_we for the first ndist busy cycles; collect results.
  task automatic run(input bit wr0, input logic [IW-1:0] w0, input int ndist,
                     input logic [AW-1:0] da, input logic [IW-1:0] dw);
    got_q.delete(); busy_cyc = 0; both_hi = 0; timed_out = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    if (wr0) begin bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_wdata = w0; prog[0] = w0; end
    @(negedge clk);
    bus.start = 1'b0; bus.prog_we = 1'b0; abort_first = bus.abort;
    for (int c = 0; c < 600; c++) begin
      if (bus.busy === 1'b1) busy_cyc++;
      if (bus.com !== NOP) got_q.push_back({bus.com, bus.datain});
      if (bus.done === 1'b1 && bus.busy === 1'b1) both_hi++;
      if (bus.done === 1'b1) begin
        got_abort = bus.abort; got_pc = bus.pc; timed_out = 1'b0;
        break;
      end
      if (c < ndist) begin bus.start = 1'b1; bus.prog_we = 1'b1; bus.prog_addr = da; bus.prog_wdata = dw; end
      else begin bus.start = 1'b0; bus.prog_we = 1'b0; end
      @(negedge clk);
    end
    bus.start = 1'b0; bus.prog_we = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.com, bus.datain, bus.busy, bus.done, bus.abort, bus.pc} !== {NOP, DW'(0), 3'b000, AW'(0)}) begin
      n_fail++;
      $display("FAIL reset: com=%h datain=%h busy=%b done=%b abort=%b pc=%0d, required all zero",
               bus.com, bus.datain, bus.busy, bus.done, bus.abort, bus.pc);
    end
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_two_issue();
    write_word(0, mk(2'd0, 3'b001, 16'h2222));
    write_word(1, mk(2'd0, 3'b110, 16'h3333));
    write_word(2, mk(2'd3, 3'b000, 16'h0000));
    preset_acc(16'h0);
    model(16'h0);
    run(1'b0, '0, 0, '0, '0);
    n_checks++;
    if (timed_out || !q_match()) begin n_fail++;
      $display("FAIL two_issue cmds: got %0d (timeout=%0b) required %0d", got_q.size(), timed_out, exp_q.size()); end
    n_checks++;
    if (busy_cyc != 6 || both_hi != 0 || got_abort !== 1'b0 || got_pc !== AW'(2)) begin n_fail++;
      $display("FAIL two_issue status: busy=%0d overlap=%0d abort=%b pc=%0d required 6/0/0/2",
               busy_cyc, both_hi, got_abort, got_pc); end
  endtask

  task automatic test_jz();
    logic [DW-1:0] accs [2];
    accs[0] = 16'h0000; accs[1] = 16'h0001;
    write_word(0, mk(2'd1, 3'b000, 16'h0003));
    write_word(1, mk(2'd0, 3'b001, 16'hAAAA));
    write_word(2, mk(2'd3, 3'b000, 16'h0000));
    write_word(3, mk(2'd0, 3'b111, 16'h5555));
    write_word(4, mk(2'd3, 3'b000, 16'h0000));
    for (int k = 0; k < 2; k++) begin
      preset_acc(accs[k]);
      model(accs[k]);
      run(1'b0, '0, 0, '0, '0);
      n_checks++;
      if (timed_out || !q_match() || got_q.size() != 1) begin n_fail++;
        $display("FAIL jz cmds acc=%h: got %0d (timeout=%0b) required %0d", accs[k], got_q.size(), timed_out, exp_q.size()); end
      n_checks++;
      if (got_pc !== exp_pc || busy_cyc != 2 * exp_steps || got_abort !== 1'b0) begin n_fail++;
        $display("FAIL jz status acc=%h: pc=%0d busy=%0d abort=%b required %0d/%0d/0",
                 accs[k], got_pc, busy_cyc, got_abort, exp_pc, 2 * exp_steps); end
    end
  endtask

  task automatic test_step_limit();
    write_word(0, mk(2'd2, 3'b000, 16'h0000));
    model(acc);
    run(1'b0, '0, 0, '0, '0);
    n_checks++;
    if (timed_out || got_q.size() != 0 || got_abort !== 1'b1 || !exp_abort) begin n_fail++;
      $display("FAIL step_limit: cmds=%0d timeout=%0b abort=%b required 0/0/1", got_q.size(), timed_out, got_abort); end
    n_checks++;
    if (busy_cyc != 2 * exp_steps + 2 || got_pc !== AW'(0)) begin n_fail++;
      $display("FAIL step_limit busy/pc: busy=%0d pc=%0d required %0d/0", busy_cyc, got_pc, 2 * exp_steps + 2); end
    write_word(0, mk(2'd3, 3'b000, 16'h0000));
    run(1'b0, '0, 0, '0, '0);
    n_checks++;
    if (abort_first !== 1'b0 || got_abort !== 1'b0 || timed_out) begin n_fail++;
      $display("FAIL restart_abort: abort after start=%b at done=%b required 0/0", abort_first, got_abort); end
  endtask

  task automatic test_wrap();
    write_word(0,  mk(2'd1, 3'b000, 16'h000E));
    write_word(1,  mk(2'd3, 3'b000, 16'h0000));
    write_word(14, mk(2'd0, 3'b011, 16'h0000));
    write_word(15, mk(2'd0, 3'b010, 16'hBEEF));
    preset_acc(16'h0);
    model(16'h0);
    run(1'b0, '0, 0, '0, '0);
    n_checks++;
    if (timed_out || !q_match() || got_q.size() != 2) begin n_fail++;
      $display("FAIL wrap cmds: got %0d (timeout=%0b) required 2", got_q.size(), timed_out); end
    n_checks++;
    if (got_pc !== AW'(1) || busy_cyc != 2 * exp_steps) begin n_fail++;
      $display("FAIL wrap status: pc=%0d busy=%0d required 1/%0d", got_pc, busy_cyc, 2 * exp_steps); end
  endtask

  task automatic test_reset_mid();
    int seen, stray;
    write_word(0, mk(2'd0, 3'b101, 16'h1111));
    write_word(1, mk(2'd0, 3'b110, 16'h2222));
    write_word(2, mk(2'd3, 3'b000, 16'h0000));
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (bus.com !== NOP) seen = 1; else @(negedge clk);
    end
    rst = 1'b1; #1;
    n_checks++;
    if (seen == 0 || bus.com !== NOP || bus.busy !== 1'b0 || bus.pc !== AW'(0) || bus.done !== 1'b0) begin n_fail++;
      $display("FAIL reset_mid: seen=%0d com=%h busy=%b pc=%0d done=%b required 1/0/0/0/0",
               seen, bus.com, bus.busy, bus.pc, bus.done); end
    @(negedge clk); rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.com !== NOP || bus.busy !== 1'b0) stray++;
      @(negedge clk);
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL reset_idle: active cycles=%0d required 0", stray); end
    preset_acc(16'h0);
    model(16'h0);
    run(1'b0, '0, 0, '0, '0);
    n_checks++;
    if (timed_out || !q_match() || got_q.size() != 2) begin n_fail++;
      $display("FAIL reset_rerun cmds: got %0d (timeout=%0b) required 2", got_q.size(), timed_out); end
  endtask

  task automatic test_busy_ignore();
    int stray;
    write_word(0, mk(2'd0, 3'b001, 16'h1234));
    write_word(1, mk(2'd3, 3'b000, 16'h0000));
    model(acc);
    run(1'b0, '0, 3, AW'(1), mk(2'd0, 3'b111, 16'h7777));
    n_checks++;
    if (timed_out || !q_match() || got_pc !== AW'(1) || busy_cyc != 4) begin n_fail++;
      $display("FAIL busy_ignore: cmds=%0d pc=%0d busy=%0d required %0d/1/4", got_q.size(), got_pc, busy_cyc, exp_q.size()); end
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    n_checks++;
    if (stray != 0) begin n_fail++; $display("FAIL no_restart: active cycles=%0d required 0", stray); end
    run(1'b0, '0, 0, '0, '0);
    n_checks++;
    if (timed_out || !q_match()) begin n_fail++;
      $display("FAIL prog_unchanged: cmds=%0d required %0d", got_q.size(), exp_q.size()); end
  endtask

  task automatic test_start_with_write();
    logic [IW-1:0] w0;
    w0 = mk(2'd0, 3'b010, 16'h4321);
    write_word(1, mk(2'd3, 3'b000, 16'h0000));
    prog[0] = w0;
    model(acc);
    run(1'b1, w0, 0, '0, '0);
    n_checks++;
    if (timed_out || !q_match() || got_q.size() != 1) begin n_fail++;
      $display("FAIL start_with_write: cmds=%0d (timeout=%0b) required 1", got_q.size(), timed_out); end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [SW-1:0] sel;
    logic [DW-1:0] d, a0;
    int r;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NWORDS; i++) begin
        r = $urandom_range(0, 19);
        op = (r < 10) ? 2'd0 : (r < 14) ? 2'd1 : (r < 17) ? 2'd2 : 2'd3;
        sel = SW'($urandom_range(1, 7));
        d = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
        write_word(i, mk(op, sel, d));
      end
      a0 = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom);
      preset_acc(a0);
      model(a0);
      run(1'b0, '0, 0, '0, '0);
      n_checks++;
      if (timed_out || !q_match()) begin n_fail++;
        $display("FAIL random%0d cmds: got %0d (timeout=%0b) required %0d", it, got_q.size(), timed_out, exp_q.size()); end
      n_checks++;
      if (got_abort !== exp_abort || got_pc !== exp_pc || both_hi != 0 ||
          busy_cyc != 2 * exp_steps + (exp_abort ? 2 : 0)) begin n_fail++;
        $display("FAIL random%0d status: abort=%b pc=%0d busy=%0d overlap=%0d required %b/%0d/%0d/0", it,
                 got_abort, got_pc, busy_cyc, both_hi, exp_abort, exp_pc, 2 * exp_steps + (exp_abort ? 2 : 0)); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
    foreach (prog[i]) prog[i] = '0;
    test_reset();
    test_two_issue();
    test_jz();
    test_step_limit();
    test_wrap();
    test_reset_mid();
    test_busy_ignore();
    test_start_with_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
